// File: rtl/neopixel_pkg.sv
// Shared NeoPixel protocol definitions: receiver state encoding and the bit/latch
// timing that both the strand controller and this receiver use.
package neopixel_pkg;

    localparam int BITS_PER_PIXEL = 24;

    localparam int DEF_NUM_PIXELS   = 5;
    localparam int DEF_BIT_THRESH   = 26;
    localparam int DEF_MIN_HIGH     = 8;
    localparam int DEF_MAX_HIGH     = 60;
    localparam int DEF_RESET_CYCLES = 2500;

    // Transmit pulse widths in clock cycles at 50 MHz.
    localparam int T0H_CYCLES = 18;
    localparam int T0L_CYCLES = 32;
    localparam int T1H_CYCLES = 35;
    localparam int T1L_CYCLES = 15;

    typedef enum logic [1:0] {
        ST_UNARMED = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HIGH    = 2'd2,
        ST_LOW     = 2'd3
    } neo_state_t;

    function automatic int packet_bits(input int num_pixels);
        return BITS_PER_PIXEL * num_pixels;
    endfunction

endpackage

// File: rtl/neo_line_sync.sv
// Two-flop synchronizer for the strand data line with registered edge strobes
// that coincide with the synced level changing.
module neo_line_sync (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_rise;
    logic r_fall;

    // Synchronize the line and derive single-cycle rise/fall strobes.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_rise <= r_meta & ~r_sync;
            r_fall <= ~r_meta & r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/neopixel_strand_receiver.sv
// NeoPixel receive decoder: measures high-pulse widths, assembles GRB pixels
// MSB-first and publishes the whole strand when a latch gap closes the frame.
module neopixel_strand_receiver
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
    parameter int BIT_THRESH   = DEF_BIT_THRESH,
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int MAX_HIGH     = DEF_MAX_HIGH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic                                     neo_data,
    output logic [BITS_PER_PIXEL*NUM_PIXELS-1:0]     display_packet,
    output logic                                     frame_valid,
    output logic                                     frame_error,
    output logic [$clog2(BITS_PER_PIXEL*NUM_PIXELS+2)-1:0] bit_count,
    output logic                                     busy
);

    localparam int PKT_W = packet_bits(NUM_PIXELS);
    localparam int BC_W  = $clog2(PKT_W + 2);
    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MINHI = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] CNT_MAXHI = CNT_W'(MAX_HIGH);
    localparam logic [CNT_W-1:0] CNT_THR   = CNT_W'(BIT_THRESH);

    localparam logic [BC_W-1:0]  BC_ZERO = {BC_W{1'b0}};
    localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
    localparam logic [BC_W-1:0]  BC_FULL = BC_W'(PKT_W);
    localparam logic [BC_W-1:0]  BC_SAT  = BC_W'(PKT_W + 1);

    logic w_level;
    logic w_rise;
    logic w_fall;
    logic w_bit_one;
    logic w_hi_bad;

    neo_state_t         r_state;
    logic [CNT_W-1:0]   r_hi_cnt;
    logic [CNT_W-1:0]   r_lo_cnt;
    logic [PKT_W-1:0]   r_shift;
    logic [PKT_W-1:0]   r_display;
    logic [BC_W-1:0]    r_bit_count;
    logic               r_frame_valid;
    logic               r_frame_error;
    logic               r_busy;

    neo_line_sync u_line_sync (
        .i_clock   (clock),
        .i_reset_n (reset_n),
        .i_line    (neo_data),
        .o_level   (w_level),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign w_bit_one = (r_hi_cnt >= CNT_THR);
    assign w_hi_bad  = (r_hi_cnt < CNT_MINHI) || (r_hi_cnt > CNT_MAXHI);

    // Receive state machine: arming, pulse measurement, bit assembly, frame publish.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_UNARMED;
            r_hi_cnt      <= CNT_ZERO;
            r_lo_cnt      <= CNT_ZERO;
            r_shift       <= {PKT_W{1'b0}};
            r_display     <= {PKT_W{1'b0}};
            r_bit_count   <= BC_ZERO;
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                ST_UNARMED: begin
                    r_busy <= 1'b0;
                    if (w_level) begin
                        r_lo_cnt <= CNT_ZERO;
                    end else if (r_lo_cnt >= CNT_GAP) begin
                        r_lo_cnt <= CNT_ZERO;
                        r_state  <= ST_ARMED;
                    end else begin
                        r_lo_cnt <= sat_inc(r_lo_cnt);
                    end
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        r_hi_cnt <= CNT_ONE;
                        r_busy   <= 1'b1;
                        r_state  <= ST_HIGH;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    // A pulse outside the legal window, or a line stuck high, aborts the frame.
                    if ((w_fall && w_hi_bad) || (!w_fall && (r_hi_cnt > CNT_MAXHI))) begin
                        r_frame_error <= 1'b1;
                        r_bit_count   <= BC_ZERO;
                        r_lo_cnt      <= CNT_ZERO;
                        r_busy        <= 1'b0;
                        r_state       <= ST_UNARMED;
                    end else if (w_fall) begin
                        if (r_bit_count < BC_FULL) begin
                            r_shift <= {r_shift[PKT_W-2:0], w_bit_one};
                        end else begin
                            r_shift <= r_shift;
                        end
                        r_bit_count <= (r_bit_count < BC_SAT) ? r_bit_count + BC_ONE : r_bit_count;
                        r_lo_cnt    <= CNT_ONE;
                        r_state     <= ST_LOW;
                    end else begin
                        r_hi_cnt <= sat_inc(r_hi_cnt);
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        r_hi_cnt <= CNT_ONE;
                        r_state  <= ST_HIGH;
                    end else if (r_lo_cnt >= CNT_GAP) begin
                        if (r_bit_count == BC_FULL) begin
                            r_display     <= r_shift;
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                        r_bit_count <= BC_ZERO;
                        r_lo_cnt    <= CNT_ZERO;
                        r_busy      <= 1'b0;
                        r_state     <= ST_ARMED;
                    end else begin
                        r_lo_cnt <= sat_inc(r_lo_cnt);
                    end
                end
                default: begin
                    r_hi_cnt    <= CNT_ZERO;
                    r_lo_cnt    <= CNT_ZERO;
                    r_bit_count <= BC_ZERO;
                    r_busy      <= 1'b0;
                    r_state     <= ST_UNARMED;
                end
            endcase
        end
    end

    assign display_packet = r_display;
    assign frame_valid    = r_frame_valid;
    assign frame_error    = r_frame_error;
    assign bit_count      = r_bit_count;
    assign busy           = r_busy;

endmodule

// File: tb/tb_neopixel_strand_receiver.sv
// Randomized bench for the NeoPixel receiver against a pixel-level frame model.
module tb_neopixel_strand_receiver;
    import neopixel_pkg::*;

    localparam int NP  = 5;
    localparam int PW  = 24 * NP;
    localparam int BCW = $clog2(PW + 2);
    localparam int GAP = 2600;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            neo_data = 1'b0;
    logic [PW-1:0]   display_packet;
    logic            frame_valid;
    logic            frame_error;
    logic [BCW-1:0]  bit_count;
    logic            busy;

    neopixel_strand_receiver dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .neo_data       (neo_data),
        .display_packet (display_packet),
        .frame_valid    (frame_valid),
        .frame_error    (frame_error),
        .bit_count      (bit_count),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Pulse monitor sampled on the falling edge.
    int fv_total = 0, fe_total = 0, overlap_total = 0, hold_viol = 0;
    logic [PW-1:0] prev_disp = '0;
    logic          prev_rst  = 1'b0;
    always @(negedge clock) begin
        if (frame_valid) fv_total <= fv_total + 1;
        if (frame_error) fe_total <= fe_total + 1;
        if (frame_valid && frame_error) overlap_total <= overlap_total + 1;
        if (reset_n && prev_rst && !frame_valid && display_packet !== prev_disp) hold_viol <= hold_viol + 1;
        prev_disp <= display_packet;
        prev_rst  <= reset_n;
    end

    // Reference model: pixel array in GRB, last published frame.
    logic [23:0]   pix [NP];
    logic [PW-1:0] exp_disp = '0;

    function automatic logic [PW-1:0] model_packet();
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < NP; k++) p[PW-1-24*k -: 24] = pix[k];
        return p;
    endfunction

    task automatic randomize_pixels();
        for (int k = 0; k < NP; k++) pix[k] = 24'($urandom);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_pulse(input int hi, input int lo);
        neo_data = 1'b1;
        wait_cyc(hi);
        neo_data = 1'b0;
        wait_cyc(lo);
    endtask

    // Nominal widths, or random widths anywhere in the legal window for each bit value.
    task automatic send_bits(input logic [PW-1:0] pkt, input int nbits, input bit nominal);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = (i < PW) ? pkt[PW-1-i] : 1'b1;
            if (nominal) begin
                if (b) drive_pulse(T1H_CYCLES, T1L_CYCLES);
                else   drive_pulse(T0H_CYCLES, T0L_CYCLES);
            end else begin
                if (b) drive_pulse(int'($urandom_range(60, 26)), int'($urandom_range(15, 6)));
                else   drive_pulse(int'($urandom_range(25, 8)), int'($urandom_range(15, 6)));
            end
        end
    endtask

    task automatic run_frame(input string tag, input int nbits, input bit nominal);
        int fv0, fe0;
        fv0 = fv_total;
        fe0 = fe_total;
        send_bits(model_packet(), nbits, nominal);
        check_eq({tag, "_bitcnt"}, 128'(bit_count), 128'((nbits > PW) ? PW + 1 : nbits));
        check_eq({tag, "_busy"}, 128'(busy), 128'(1));
        neo_data = 1'b0;
        wait_cyc(GAP);
        if (nbits == PW) exp_disp = model_packet();
        check_eq({tag, "_valid"}, 128'(fv_total - fv0), 128'((nbits == PW) ? 1 : 0));
        check_eq({tag, "_error"}, 128'(fe_total - fe0), 128'((nbits == PW) ? 0 : 1));
        check_eq({tag, "_packet"}, 128'(display_packet), 128'(exp_disp));
        check_eq({tag, "_bitcnt_end"}, 128'(bit_count), 128'(0));
        check_eq({tag, "_idle"}, 128'(busy), 128'(0));
    endtask

    int fv0, fe0;

    initial begin
        for (int k = 0; k < NP; k++) pix[k] = 24'h0;
        reset_n  = 1'b0;
        neo_data = 1'b0;
        wait_cyc(3);
        check_eq("rst_packet", 128'(display_packet), 128'(0));
        check_eq("rst_valid", 128'(frame_valid), 128'(0));
        check_eq("rst_error", 128'(frame_error), 128'(0));
        check_eq("rst_bitcnt", 128'(bit_count), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        reset_n = 1'b1;

        // Toggling straight out of reset must never be decoded.
        fv0 = fv_total; fe0 = fe_total;
        randomize_pixels();
        send_bits(model_packet(), 40, 1'b0);
        check_eq("noarm_busy", 128'(busy), 128'(0));
        neo_data = 1'b0;
        wait_cyc(GAP);
        check_eq("noarm_pulses", 128'((fv_total - fv0) + (fe_total - fe0)), 128'(0));

        for (int k = 0; k < NP; k++) pix[k] = 24'h0;
        run_frame("zero", PW, 1'b1);

        for (int k = 0; k < NP; k++) pix[k] = 24'h0;
        pix[4] = 24'h00FF00;
        pix[0] = {8'h00, 8'h50, 8'h73};
        pix[2] = 24'hB30000;
        run_frame("pattern", PW, 1'b1);
        check_eq("pattern_px0", 128'(display_packet[119:96]), 128'(24'h005073));
        check_eq("pattern_px2", 128'(display_packet[71:48]), 128'(24'hB30000));
        check_eq("pattern_px4", 128'(display_packet[23:0]), 128'(24'h00FF00));

        for (int r = 0; r < 2; r++) begin
            randomize_pixels();
            run_frame("random", PW, 1'b0);
        end

        randomize_pixels();
        run_frame("short", 96, 1'b0);
        randomize_pixels();
        run_frame("overrun", PW + 1, 1'b0);

        // Glitch mid-frame, then a gapless frame that must be ignored.
        randomize_pixels();
        fv0 = fv_total; fe0 = fe_total;
        send_bits(model_packet(), 30, 1'b0);
        drive_pulse(5, 32);
        check_eq("glitch_error", 128'(fe_total - fe0), 128'(1));
        check_eq("glitch_busy", 128'(busy), 128'(0));
        check_eq("glitch_bitcnt", 128'(bit_count), 128'(0));
        fe0 = fe_total;
        send_bits(model_packet(), 40, 1'b0);
        neo_data = 1'b0;
        wait_cyc(GAP);
        check_eq("glitch_ignored", 128'((fv_total - fv0) + (fe_total - fe0)), 128'(0));
        randomize_pixels();
        run_frame("post_glitch", PW, 1'b0);

        // Line stuck high: error is taken before the line falls.
        randomize_pixels();
        fv0 = fv_total; fe0 = fe_total;
        send_bits(model_packet(), 20, 1'b0);
        neo_data = 1'b1;
        wait_cyc(75);
        check_eq("stuck_error", 128'(fe_total - fe0), 128'(1));
        check_eq("stuck_busy", 128'(busy), 128'(0));
        wait_cyc(30);
        neo_data = 1'b0;
        wait_cyc(GAP);
        check_eq("stuck_quiet", 128'((fv_total - fv0) + (fe_total - fe0)), 128'(1));
        randomize_pixels();
        run_frame("post_stuck", PW, 1'b0);

        // Reset in the middle of a frame.
        randomize_pixels();
        fv0 = fv_total; fe0 = fe_total;
        send_bits(model_packet(), 60, 1'b0);
        reset_n = 1'b0;
        wait_cyc(1);
        exp_disp = '0;
        check_eq("midrst_packet", 128'(display_packet), 128'(exp_disp));
        check_eq("midrst_bitcnt", 128'(bit_count), 128'(0));
        check_eq("midrst_busy", 128'(busy), 128'(0));
        wait_cyc(1);
        reset_n = 1'b1;
        neo_data = 1'b0;
        wait_cyc(GAP);
        check_eq("midrst_pulses", 128'((fv_total - fv0) + (fe_total - fe0)), 128'(0));
        randomize_pixels();
        run_frame("post_reset", PW, 1'b0);

        wait_cyc(2);
        check_eq("never_both", 128'(overlap_total), 128'(0));
        check_eq("packet_hold", 128'(hold_viol), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
